ava_master_cmdq: RTL and testbench

//  Synthesizable, parametrised Avalon-MM single-word master with a command queue.

---
 rtl/ava_master_cmdq.sv | 231 +++++++++++++++++++++++
 tb/tb_ava_master_cmdq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ava_master_cmdq.sv
// rtl/ava_master_cmdq.sv - Avalon-MM single-word master fed by a DEPTH-entry command FIFO
//
// Purpose: local logic pushes read/write commands; an issue engine replays them
// one word at a time on the Avalon bus, honouring master_waitrequest, and
// returns one response pulse per command.
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake (push = valid & ready)
//   cmd_write/cmd_addr/cmd_be/cmd_wdata  command fields
//   rsp_valid/rsp_write/rsp_rdata/rsp_err  one-cycle response per command
//   busy                             FIFO non-empty or transfer in flight
//   master_*                         Avalon-MM master interface
//
// Optional macro AVA_MASTER_CMDQ_TIMEOUT_EN: abort a transfer after TIMEOUT
// consecutive waitrequest cycles and report it with rsp_err=1.
module ava_master_cmdq #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int BEW     = DW / 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_write,
    input  logic [AW-1:0]  cmd_addr,
    input  logic [BEW-1:0] cmd_be,
    input  logic [DW-1:0]  cmd_wdata,
    output logic           rsp_valid,
    output logic           rsp_write,
    output logic [DW-1:0]  rsp_rdata,
    output logic           rsp_err,
    output logic           busy,
    output logic [AW-1:0]  master_address,
    output logic           master_write,
    output logic           master_read,
    output logic [BEW-1:0] master_byteenable,
    output logic [DW-1:0]  master_writedata,
    input  logic [DW-1:0]  master_readdata,
    input  logic           master_waitrequest
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 1 + AW + BEW + DW;

    if (BEW != DW / 8 || DW % 8 != 0 || DEPTH < 2 || (1 << PW) != DEPTH || TIMEOUT < 1) begin : g_bad_param
        $error("ava_master_cmdq: illegal parameter combination");
    end

    typedef enum logic [0:0] {ST_IDLE, ST_ISSUE} state_t;

    state_t         state_q, state_d;
    logic [EW-1:0]  mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic           master_write_q, master_write_d;
    logic           master_read_q, master_read_d;
    logic [AW-1:0]  master_address_q, master_address_d;
    logic [BEW-1:0] master_byteenable_q, master_byteenable_d;
    logic [DW-1:0]  master_writedata_q, master_writedata_d;

    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_write_q, rsp_write_d;
    logic [DW-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic           rsp_err_q, rsp_err_d;

    logic           push, pop;
    logic           fifo_empty;
    logic           xfer_done, xfer_abort;
    logic           head_write;
    logic [AW-1:0]  head_addr;
    logic [BEW-1:0] head_be;
    logic [DW-1:0]  head_wdata;

    assign fifo_empty = (count_q == '0);
    assign cmd_ready  = (count_q != CW'(DEPTH));
    assign push       = cmd_valid & cmd_ready;
    assign busy       = !fifo_empty || (state_q == ST_ISSUE);

    assign {head_write, head_addr, head_be, head_wdata} = mem_q[rd_ptr_q];

    // In ISSUE a strobe is always asserted, so completion is just !waitrequest.
    assign xfer_done = (state_q == ST_ISSUE) && !master_waitrequest;

`ifdef AVA_MASTER_CMDQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;

    // Abort on the edge that would take the stall count to TIMEOUT, i.e. after
    // TIMEOUT consecutive stalled strobe cycles.
    assign xfer_abort = (state_q == ST_ISSUE) && master_waitrequest
                        && (to_cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (pop) begin
            to_cnt_d = '0;
        end else if (state_q == ST_ISSUE && master_waitrequest) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign xfer_abort = 1'b0;
`endif

    always_comb begin
        state_d             = state_q;
        pop                 = 1'b0;
        master_write_d      = master_write_q;
        master_read_d       = master_read_q;
        master_address_d    = master_address_q;
        master_byteenable_d = master_byteenable_q;
        master_writedata_d  = master_writedata_q;
        rsp_valid_d         = 1'b0;
        rsp_write_d         = 1'b0;
        rsp_rdata_d         = '0;
        rsp_err_d           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (xfer_done || xfer_abort) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = master_write_q;
                    rsp_err_d   = xfer_abort;
                    if (xfer_done && master_read_q) begin
                        rsp_rdata_d = master_readdata;
                    end
                    // Chain straight into the next queued command (no bubble).
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        master_write_d = 1'b0;
                        master_read_d  = 1'b0;
                        state_d        = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            master_write_d      = head_write;
            master_read_d       = !head_write;
            master_address_d    = head_addr;
            master_byteenable_d = head_be;
            master_writedata_d  = head_wdata;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset: entries are only read once counted in.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_be, cmd_wdata};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q             <= ST_IDLE;
            wr_ptr_q            <= '0;
            rd_ptr_q            <= '0;
            count_q             <= '0;
            master_write_q      <= 1'b0;
            master_read_q       <= 1'b0;
            master_address_q    <= '0;
            master_byteenable_q <= '0;
            master_writedata_q  <= '0;
            rsp_valid_q         <= 1'b0;
            rsp_write_q         <= 1'b0;
            rsp_rdata_q         <= '0;
            rsp_err_q           <= 1'b0;
        end else begin
            state_q             <= state_d;
            wr_ptr_q            <= wr_ptr_d;
            rd_ptr_q            <= rd_ptr_d;
            count_q             <= count_d;
            master_write_q      <= master_write_d;
            master_read_q       <= master_read_d;
            master_address_q    <= master_address_d;
            master_byteenable_q <= master_byteenable_d;
            master_writedata_q  <= master_writedata_d;
            rsp_valid_q         <= rsp_valid_d;
            rsp_write_q         <= rsp_write_d;
            rsp_rdata_q         <= rsp_rdata_d;
            rsp_err_q           <= rsp_err_d;
        end
    end

    assign master_write      = master_write_q;
    assign master_read       = master_read_q;
    assign master_address    = master_address_q;
    assign master_byteenable = master_byteenable_q;
    assign master_writedata  = master_writedata_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_write         = rsp_write_q;
    assign rsp_rdata         = rsp_rdata_q;
    assign rsp_err           = rsp_err_q;

endmodule

// File: tb/tb_ava_master_cmdq.sv
// tb/tb_ava_master_cmdq.sv - scoreboard bench for ava_master_cmdq
module tb_ava_master_cmdq;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int BEW     = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic           cmd_write = 1'b0;
    logic [AW-1:0]  cmd_addr = '0;
    logic [BEW-1:0] cmd_be = '0;
    logic [DW-1:0]  cmd_wdata = '0;
    logic           rsp_valid, rsp_write, rsp_err, busy;
    logic [DW-1:0]  rsp_rdata;
    logic [AW-1:0]  master_address;
    logic           master_write, master_read;
    logic [BEW-1:0] master_byteenable;
    logic [DW-1:0]  master_writedata, master_readdata;
    logic           master_waitrequest;

    ava_master_cmdq #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .master_address(master_address), .master_write(master_write),
        .master_read(master_read), .master_byteenable(master_byteenable),
        .master_writedata(master_writedata), .master_readdata(master_readdata),
        .master_waitrequest(master_waitrequest)
    );

    always #5 clk = ~clk;

    // Slave model: fixed stall count per transfer plus a global stall override.
    logic force_wait = 1'b0;
    int   stall_per_xfer = 0;
    int   stall_cnt;
    wire  strobe = master_read | master_write;

    assign master_waitrequest = force_wait || (strobe && stall_cnt < stall_per_xfer);
    assign master_readdata    = (master_address == 32'h204) ? 32'h1234_5678
                                                            : {16'hC0DE, master_address[15:0]};

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)    stall_cnt <= 0;
        else if (strobe) stall_cnt <= master_waitrequest ? stall_cnt + 1 : 0;
    end

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] d;
        int          len;
    } bus_t;
    typedef struct {
        bit          w;
        logic [31:0] rd;
        bit          err;
    } rsp_t;

    bus_t exp_bus[$];
    rsp_t exp_rsp[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: bus-side and response-side scoreboards.
    initial begin : monitor
        int          cur_len;
        bit          prev_stall;
        logic [31:0] p_a, p_d;
        logic [3:0]  p_be;
        logic [1:0]  p_rw;
        bus_t        b;
        rsp_t        r;
        bit          finish_xfer;
        cur_len = 0;
        prev_stall = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                cur_len = 0;
                prev_stall = 0;
                continue;
            end
            if (prev_stall) begin
                check("hold_addr", master_address, p_a);
                check("hold_be", master_byteenable, p_be);
                check("hold_wdata", master_writedata, p_d);
                check("hold_strobe", {master_read, master_write}, p_rw);
            end
            if (strobe) begin
                cur_len++;
                check("one_strobe", master_read & master_write, 0);
                finish_xfer = !master_waitrequest;
`ifdef AVA_MASTER_CMDQ_TIMEOUT_EN
                if (master_waitrequest && cur_len == TIMEOUT) finish_xfer = 1;
`endif
                if (finish_xfer) begin
                    check("bus_expected", exp_bus.size() != 0, 1);
                    if (exp_bus.size() != 0) begin
                        b = exp_bus.pop_front();
                        check("bus_write", master_write, b.w);
                        check("bus_addr", master_address, b.a);
                        check("bus_be", master_byteenable, b.be);
                        if (b.w) check("bus_wdata", master_writedata, b.d);
                        if (b.len >= 0) check("bus_len", cur_len, b.len);
                    end
                    cur_len = 0;
                end
            end
            prev_stall = strobe && master_waitrequest;
            p_a = master_address;
            p_be = master_byteenable;
            p_d = master_writedata;
            p_rw = {master_read, master_write};
            if (rsp_valid) begin
                check("rsp_expected", exp_rsp.size() != 0, 1);
                if (exp_rsp.size() != 0) begin
                    r = exp_rsp.pop_front();
                    check("rsp_write", rsp_write, r.w);
                    check("rsp_rdata", rsp_rdata, r.rd);
                    check("rsp_err", rsp_err, r.err);
                end
            end
        end
    end

    // Expectations are queued at the edge the command is accepted.
    task automatic expect_cmd(bit w, logic [31:0] a, logic [3:0] be, logic [31:0] d,
                              logic [31:0] rd, bit err, int len);
        bus_t b;
        rsp_t r;
        b.w = w; b.a = a; b.be = be; b.d = d; b.len = len;
        r.w = w; r.rd = rd; r.err = err;
        exp_bus.push_back(b);
        exp_rsp.push_back(r);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(bit w, logic [31:0] a, logic [3:0] be, logic [31:0] d,
                        logic [31:0] rd, int len);
        int n;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_be = be; cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("push_accept_wait", n < 100, 1);
        if (cmd_ready) expect_cmd(w, a, be, d, rd, 1'b0, len);
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_rsp.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", n < 300, 1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_strobes", {master_read, master_write}, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        reset_n = 1;
        @(posedge clk); #1;

        // Single write, no stall: strobe exactly one cycle
        stall_per_xfer = 0;
        push(1, 32'h100, 4'hF, 32'hDEAD_BEEF, 32'h0, 1);
        wait_idle();

        // Read with 3 stall cycles: strobe 4 cycles, fields held
        stall_per_xfer = 3;
        push(0, 32'h204, 4'h3, 32'h0, 32'h1234_5678, 4);
        wait_idle();

        // Fill: 1 in flight + DEPTH queued, 6th refused, then back-to-back drain
        stall_per_xfer = 0;
        force_wait = 1;
        push(1, 32'h10, 4'hF, 32'h1111_1111, 32'h0, -1);
        push(0, 32'h14, 4'hF, 32'h0, 32'hC0DE_0014, 1);
        push(1, 32'h18, 4'h3, 32'h2222_2222, 32'h0, 1);
        push(0, 32'h1C, 4'hC, 32'h0, 32'hC0DE_001C, 1);
        push(1, 32'h20, 4'h1, 32'h3333_3333, 32'h0, 1);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h24; cmd_be = 4'hF;
        check("full_ready", cmd_ready, 0);
        check("full_busy", busy, 1);
        @(posedge clk); #1;
        cmd_valid = 0;
        force_wait = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("b2b_strobe", strobe, 1);
        end
        @(negedge clk);
        check("drain_strobe_low", strobe, 0);
        wait_idle();

        // Simultaneous push and pop at count = DEPTH-1
        force_wait = 1;
        push(1, 32'h40, 4'hF, 32'h4040_4040, 32'h0, -1);
        push(0, 32'h44, 4'hF, 32'h0, 32'hC0DE_0044, -1);
        push(1, 32'h48, 4'hF, 32'h4848_4848, 32'h0, 1);
        push(0, 32'h4C, 4'hF, 32'h0, 32'hC0DE_004C, 1);
        check("pre_simul_ready", cmd_ready, 1);
        force_wait = 0;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h50; cmd_be = 4'hF; cmd_wdata = 32'h5050_5050;
        expect_cmd(1, 32'h50, 4'hF, 32'h5050_5050, 32'h0, 1'b0, 1);
        @(posedge clk); #1;
        cmd_valid = 0;
        force_wait = 1;
        check("simul_ready", cmd_ready, 1);
        push(0, 32'h54, 4'hF, 32'h0, 32'hC0DE_0054, 1);
        check("simul_full_after", cmd_ready, 0);
        force_wait = 0;
        wait_idle();

`ifdef AVA_MASTER_CMDQ_TIMEOUT_EN
        // Stuck read aborts after TIMEOUT stalls; next command then issues
        begin
            int n;
            force_wait = 1;
            cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h300; cmd_be = 4'hF;
            expect_cmd(0, 32'h300, 4'hF, 32'h0, 32'h0, 1'b1, TIMEOUT);
            @(posedge clk); #1;
            push(1, 32'h304, 4'hF, 32'h4444_4444, 32'h0, -1);
            n = 0;
            while (!rsp_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("abort_seen", rsp_valid, 1);
            @(posedge clk); #1;
            force_wait = 0;
            wait_idle();
        end
`endif

        // Reset in the middle of a stalled transfer with a queued command
        force_wait = 1;
        push(1, 32'h60, 4'hF, 32'h6060_6060, 32'h0, -1);
        push(0, 32'h64, 4'hF, 32'h0, 32'h0, -1);
        #1;
        reset_n = 0;
        #1;
        exp_bus.delete();
        exp_rsp.delete();
        check("mid_rst_strobes", {master_read, master_write}, 0);
        check("mid_rst_addr", master_address, 0);
        check("mid_rst_be", master_byteenable, 0);
        check("mid_rst_wdata", master_writedata, 0);
        check("mid_rst_rsp", {rsp_valid, rsp_write, rsp_err}, 0);
        check("mid_rst_rdata", rsp_rdata, 0);
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_busy", busy, 0);
        force_wait = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        @(posedge clk); #1;
        check("post_rst_busy", busy, 0);
        push(0, 32'h204, 4'hF, 32'h0, 32'h1234_5678, 1);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
